// File: rtl/memory_fill_fsm.sv
// memory_fill_fsm
// Upstream stage of the display buffer. Accepts a byte stream over valid/ready
// and writes one frame into the buffer RAM starting at address 0. A terminator
// byte ends the frame early and the remaining entries are padded; bytes beyond
// a full buffer are dropped and flagged. `done` tells the reader the buffer is
// complete and stays high until the next start.
module memory_fill_fsm #(
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] TERM_CHAR = DATA_W'(8'h0A),
  parameter logic [DATA_W-1:0] PAD_CHAR  = DATA_W'(8'h20)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   length,
  output logic              overflow
);

  // ptr/length carry one extra bit so a completely full buffer (DEPTH) is representable
  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 32'd1 << ADDR_W;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_PAD   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    r_length;
  logic                r_overflow;
  logic                r_done;
  logic                r_busy;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;

  state_t              w_state_nxt;
  logic [PTR_W-1:0]    w_ptr_nxt;
  logic [PTR_W-1:0]    w_length_nxt;
  logic                w_overflow_nxt;
  logic                w_done_nxt;
  logic                w_busy_nxt;
  logic                w_wr_en_nxt;
  logic [ADDR_W-1:0]   w_wr_addr_nxt;
  logic [DATA_W-1:0]   w_wr_data_nxt;
  logic                w_in_ready;
  logic                w_xfer;
  logic                w_is_term;
  logic                w_last_slot;

  // Input handshake: the stream is consumed while filling and while draining a full buffer
  assign w_in_ready  = (r_state == S_FILL) || (r_state == S_DRAIN);
  assign w_xfer      = in_valid && w_in_ready;
  assign w_is_term   = (in_data == TERM_CHAR);
  assign w_last_slot = (r_ptr == LAST_PTR);

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_length_nxt   = r_length;
    w_overflow_nxt = r_overflow;
    w_done_nxt     = r_done;
    w_wr_en_nxt    = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt    = S_FILL;
          w_ptr_nxt      = '0;
          w_length_nxt   = '0;
          w_overflow_nxt = 1'b0;
          w_done_nxt     = 1'b0;
        end
      end

      S_FILL: begin
        if (w_xfer) begin
          if (w_is_term) begin
            // Terminator is consumed without a write; padding starts next cycle
            w_state_nxt = S_PAD;
          end else begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = r_ptr[ADDR_W-1:0];
            w_wr_data_nxt = in_data;
            w_ptr_nxt     = r_ptr + PTR_ONE;
            w_length_nxt  = r_length + PTR_ONE;
            if (w_last_slot) begin
              w_state_nxt = S_DRAIN;
            end
          end
        end
      end

      S_PAD: begin
        // One pad write per cycle up to the last entry, which also completes the frame
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = r_ptr[ADDR_W-1:0];
        w_wr_data_nxt = PAD_CHAR;
        w_ptr_nxt     = r_ptr + PTR_ONE;
        if (w_last_slot) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end
      end

      S_DRAIN: begin
        // Buffer is full: swallow bytes until the terminator arrives
        if (w_xfer) begin
          if (w_is_term) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_overflow_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_FILL) || (w_state_nxt == S_PAD) ||
                 (w_state_nxt == S_DRAIN);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_length   <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_length   <= w_length_nxt;
      r_overflow <= w_overflow_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
    end
  end

  assign in_ready = w_in_ready;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign length   = r_length;
  assign overflow = r_overflow;

endmodule
